// File: rtl/blk_mem_gen_0.sv
// Single-port 4x16 block RAM holding the seven-segment display value table.
// Registered read port, write-first on write cycles; contents survive reset.
module blk_mem_gen_0 #(
   parameter int                    DATA_WIDTH = 16,
   parameter int                    ADDR_WIDTH = 2,
   parameter logic [DATA_WIDTH-1:0] INIT_0     = 16'd1234,
   parameter logic [DATA_WIDTH-1:0] INIT_1     = 16'd5678,
   parameter logic [DATA_WIDTH-1:0] INIT_2     = 16'd9012,
   parameter logic [DATA_WIDTH-1:0] INIT_3     = 16'd3456
) (
   input  logic                  clka,
   input  logic                  reset_n,
   input  logic                  ena,
   input  logic                  wea,
   input  logic [ADDR_WIDTH-1:0] addra,
   input  logic [DATA_WIDTH-1:0] dina,
   output logic [DATA_WIDTH-1:0] douta
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   function automatic logic [DATA_WIDTH-1:0] init_word(input int idx);
      case (idx)
         0:       return INIT_0;
         1:       return INIT_1;
         2:       return INIT_2;
         3:       return INIT_3;
         default: return '0;
      endcase
   endfunction

   logic                  wr_en;
   logic [DATA_WIDTH-1:0] mem_rd [DEPTH];

   // Writes are blocked while reset is held so the table cannot be corrupted.
   assign wr_en = reset_n & ena & wea;

   // Array words carry their table value from configuration and are never reset.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic [DATA_WIDTH-1:0] word = init_word(i);

      always_ff @(posedge clka) begin
         if (wr_en && (addra == ADDR_WIDTH'(i))) begin
            word <= dina;
         end
      end

      assign mem_rd[i] = word;
   end

   always_ff @(posedge clka or negedge reset_n) begin
      if (!reset_n) begin
         douta <= '0;
      end else if (ena) begin
         douta <= wea ? dina : mem_rd[addra];
      end
   end

endmodule

// File: tb/tb_blk_mem_gen_0.sv
// Directed bench for blk_mem_gen_0: reads, write-first, disabled port and
// reset behaviour, against hand-computed table values.
module tb_blk_mem_gen_0;

   logic        clka;
   logic        reset_n;
   logic        ena;
   logic        wea;
   logic [1:0]  addra;
   logic [15:0] dina;
   logic [15:0] douta;

   int errors = 0;
   int checks = 0;

   blk_mem_gen_0 dut (
      .clka    (clka),
      .reset_n (reset_n),
      .ena     (ena),
      .wea     (wea),
      .addra   (addra),
      .dina    (dina),
      .douta   (douta)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
      end
   endtask

   // Drive after a falling edge, let one rising edge pass, sample on the next falling edge.
   task automatic access(input logic en, input logic we, input logic [1:0] addr,
                         input logic [15:0] din);
      ena   = en;
      wea   = we;
      addra = addr;
      dina  = din;
      @(posedge clka);
      @(negedge clka);
   endtask

   logic [15:0] held;
   logic [15:0] rd_exp [4];

   initial begin
      rd_exp[0] = 16'd1234;
      rd_exp[1] = 16'd5678;
      rd_exp[2] = 16'd9012;
      rd_exp[3] = 16'd3456;

      reset_n = 1'b0;
      ena     = 1'b0;
      wea     = 1'b0;
      addra   = 2'd0;
      dina    = 16'd0;
      #2;
      check_val("reset_async", douta, 16'd0);
      repeat (2) @(negedge clka);
      check_val("reset_held", douta, 16'd0);
      reset_n = 1'b1;

      access(1'b0, 1'b0, 2'd1, 16'd0);
      check_val("idle_after_reset", douta, 16'd0);

      access(1'b1, 1'b0, 2'd0, 16'd0);
      check_val("first_read_a0", douta, 16'd1234);

      // Sequential reads with wrap 3 -> 0.
      for (int i = 1; i <= 4; i++) begin
         access(1'b1, 1'b0, 2'(i), 16'd0);
         check_val($sformatf("seq_read_a%0d", i % 4), douta, rd_exp[i % 4]);
      end

      // Mid-run reset pulse: douta clears without a clock edge.
      reset_n = 1'b0;
      #2;
      check_val("midrun_reset_async", douta, 16'd0);
      @(negedge clka);
      check_val("midrun_reset_held", douta, 16'd0);
      reset_n = 1'b1;
      access(1'b1, 1'b0, 2'd0, 16'd0);
      check_val("read_after_reset_a0", douta, 16'd1234);

      access(1'b1, 1'b1, 2'd2, 16'd4321);
      check_val("write_first_a2", douta, 16'd4321);
      access(1'b1, 1'b0, 2'd2, 16'd0);
      check_val("read_back_a2", douta, 16'd4321);
      access(1'b1, 1'b0, 2'd1, 16'd0);
      check_val("untouched_a1", douta, 16'd5678);

      held = 16'd5678;
      for (int i = 0; i < 3; i++) begin
         access(1'b0, 1'b1, 2'd0, 16'hFFFF);
         check_val($sformatf("disabled_hold_%0d", i), douta, held);
      end
      access(1'b1, 1'b0, 2'd0, 16'd0);
      check_val("disabled_no_write_a0", douta, 16'd1234);

      access(1'b1, 1'b1, 2'd3, 16'd7777);
      check_val("write_first_a3", douta, 16'd7777);
      ena = 1'b0;
      wea = 1'b0;
      reset_n = 1'b0;
      #2;
      check_val("reset_after_write", douta, 16'd0);
      @(negedge clka);
      reset_n = 1'b1;
      access(1'b1, 1'b0, 2'd3, 16'd0);
      check_val("reset_keeps_a3", douta, 16'd7777);

      // Write attempted while reset is asserted must be dropped.
      ena     = 1'b1;
      wea     = 1'b1;
      addra   = 2'd1;
      dina    = 16'd1111;
      reset_n = 1'b0;
      @(posedge clka);
      @(negedge clka);
      check_val("reset_during_write", douta, 16'd0);
      reset_n = 1'b1;
      access(1'b1, 1'b0, 2'd1, 16'd0);
      check_val("reset_blocks_write_a1", douta, 16'd5678);
      access(1'b1, 1'b0, 2'd2, 16'd0);
      check_val("final_a2", douta, 16'd4321);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/blk_mem_gen_0.md
Name: blk_mem_gen_0

Overview:
- Single-port synchronous block RAM, 4 words x 16 bits, with a registered read port.
- Holds the table of values that the seven-segment display controller steps through.
- The controller advances the address once per second and latches douta into its displayed number, which is shown as up to 4 decimal digits.
- Contents are preloaded from parameters at configuration and can be rewritten through the write port.

Parameters:
- DATA_WIDTH, 16, word width of dina/douta.
- ADDR_WIDTH, 2, address width; depth = 2**ADDR_WIDTH = 4.
- INIT_0, 16'd1234, initial content of address 0.
- INIT_1, 16'd5678, initial content of address 1.
- INIT_2, 16'd9012, initial content of address 2.
- INIT_3, 16'd3456, initial content of address 3.
- Addresses above 3 (when ADDR_WIDTH > 2) initialise to 0.

Ports:
- clka  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ena  input  1  port enable; when low, no read or write takes place.
- wea  input  1  write enable; only honoured when ena=1.
- addra  input  ADDR_WIDTH  word address.
- dina  input  DATA_WIDTH  write data.
- douta  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset:
  - reset_n low forces douta to 0 immediately, with no clock required, and holds it at 0 while reset_n stays low.
  - Memory array contents are NOT affected by reset; they keep their INIT values or the last written data.
  - Writes are ignored while reset_n is low.
  - Normal operation resumes on the first rising edge of clka after reset_n goes high.
- Read, on a rising edge with ena=1 and wea=0:
  - douta <= mem[addra].
  - Latency is exactly 1 clock; the address presented at edge N appears on douta after edge N.
- Write, on a rising edge with ena=1 and wea=1:
  - mem[addra] <= dina.
  - Write-first mode: douta <= dina on the same edge.
- ena=0: memory and douta both hold their values; wea, addra and dina are don't-care.
- Back-to-back accesses: one access per cycle, no stall and no handshake.
  - A read of an address on the cycle after a write to it returns the new data.
- Address wrap: addra is exactly ADDR_WIDTH bits, so there are no out-of-range accesses.
  - A caller incrementing 3 to 0 simply reads address 0 next.
- Configuration: mem initialised from INIT_0..INIT_3; douta is 0 until the first enabled edge.
- No X on douta after reset or after any enabled access to an initialised location.
- Implementation: registered memory array that synthesises to block or distributed RAM; no combinational path from addra to douta.

Test Plan:
- Reset then read: pulse reset_n low mid-run -> douta=0 at once, without a clock; release, then ena=1, wea=0, addra=0 -> douta=1234 one edge later.
- Sequential reads addra 0,1,2,3,0: each edge with ena=1 -> douta = 1234, 5678, 9012, 3456, 1234, each one cycle after its address (wrap-around check).
- Write then read:
  - addra=2, dina=16'd4321, wea=1, ena=1 -> douta=4321 on that edge (write-first).
  - Next edge wea=0, addra=2 -> douta=4321.
  - addra=1 -> douta=5678 (other words untouched).
- Disabled port: ena=0, wea=1, addra=0, dina=16'hFFFF for 3 edges -> douta holds its prior value; a later read of address 0 returns 1234.
- Reset preserves memory: write 16'd7777 to address 3, assert reset_n low -> douta=0; release and read address 3 -> 7777.
- Reset during a write cycle: reset_n low while ena=1, wea=1, addra=1, dina=16'd1111 across an edge -> douta=0 and address 1 still reads 5678 after release.
